// File: rtl/spi_slave_rx_mode0.sv
// spi_slave_rx_mode0: SPI mode-0 slave receiver, MSB-first words out as one-cycle valid pulses
//   In_clk        system clock
//   In_rst        asynchronous active-high reset
//   In_spi_cs_n   chip select (active low, asynchronous)
//   In_spi_sclk   SPI clock (idles low, asynchronous)
//   In_spi_mosi   serial data (asynchronous)
//   Out_rx_data   last completed word, held until the next one completes
//   Out_rx_valid  one-cycle pulse when Out_rx_data is new
//   Out_rx_busy   high while a frame is being shifted in
//   Out_rx_err    one-cycle pulse when a frame ends on a partial word
module spi_slave_rx_mode0 #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              In_clk,
  input  logic              In_rst,
  input  logic              In_spi_cs_n,
  input  logic              In_spi_sclk,
  input  logic              In_spi_mosi,
  output logic [DATA_W-1:0] Out_rx_data,
  output logic              Out_rx_valid,
  output logic              Out_rx_busy,
  output logic              Out_rx_err
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync, r_flush;
  logic                   r_cs_d, r_sclk_d, r_armed;
  logic [0:0]             r_state;
  logic [CW-1:0]          r_bit_cnt;
  logic [DATA_W-1:0]      r_shreg;
  logic                   w_cs_s, w_sclk_s, w_mosi_s;
  logic                   w_sclk_rise, w_cs_fall, w_cs_rise, w_last;
  logic [CW-1:0]          w_cnt_nxt;
  logic [DATA_W-1:0]      w_word;
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  // The synchronizer resets to cs_n=1, so a CS already low at reset release would look
  // like a fresh fall. r_armed only opens once a genuine high has come out of the flushed chain.
  assign w_cs_fall   = ~w_cs_s & r_cs_d & r_armed;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_last      = r_bit_cnt == LAST;
  assign w_word      = {r_shreg[DATA_W-2:0], w_mosi_s};
  // Count after this cycle's edge; the edge is applied before any coincident cs_rise.
  assign w_cnt_nxt   = !w_sclk_rise ? r_bit_cnt : w_last ? '0 : r_bit_cnt + 1'b1;
  assign Out_rx_busy = r_state == SHIFT;
  always_ff @(posedge In_clk or posedge In_rst) begin
    if (In_rst) begin
      r_cs_sync    <= '1;
      r_sclk_sync  <= '0;
      r_mosi_sync  <= '0;
      r_flush      <= '0;
      r_cs_d       <= 1'b1;
      r_sclk_d     <= 1'b0;
      r_armed      <= 1'b0;
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      Out_rx_data  <= '0;
      Out_rx_valid <= 1'b0;
      Out_rx_err   <= 1'b0;
    end else begin
      r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], In_spi_cs_n};
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], In_spi_sclk};
      r_mosi_sync  <= {r_mosi_sync[SYNC_STAGES-2:0], In_spi_mosi};
      r_flush      <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_cs_d       <= w_cs_s;
      r_sclk_d     <= w_sclk_s;
      r_armed      <= r_armed | (r_flush[SYNC_STAGES-1] & w_cs_s);
      Out_rx_valid <= 1'b0;
      Out_rx_err   <= 1'b0;
      if (r_state == IDLE) begin
        r_bit_cnt <= '0;
        if (w_cs_fall) begin
          r_state <= SHIFT;
          r_shreg <= '0;
        end
      end else begin
        r_bit_cnt <= w_cs_rise ? '0 : w_cnt_nxt;
        if (w_sclk_rise) begin
          r_shreg <= w_word;
          if (w_last) begin
            Out_rx_data  <= w_word;
            Out_rx_valid <= 1'b1;
          end
        end
        if (w_cs_rise) begin
          r_state    <= IDLE;
          Out_rx_err <= w_cnt_nxt != '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_rx_mode0.sv
// tb_spi_slave_rx_mode0: randomized frames checked against a word-level model of the receiver
module tb_spi_slave_rx_mode0;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_err;
  int         checks = 0;
  int         failures = 0;
  int         err_cnt = 0;
  int         cyc_n = 0;
  int         half = 8;
  logic [7:0] got_q[$];
  int         t_q[$];
  logic [7:0] last_data = 8'h00;
  logic       busy_bad;
  spi_slave_rx_mode0 #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .In_clk(clk),
    .In_rst(rst),
    .In_spi_cs_n(cs_n),
    .In_spi_sclk(sclk),
    .In_spi_mosi(mosi),
    .Out_rx_data(rx_data),
    .Out_rx_valid(rx_valid),
    .Out_rx_busy(rx_busy),
    .Out_rx_err(rx_err)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc_n++;
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      t_q.push_back(cyc_n);
    end
    if (rx_err) err_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask
  task automatic send_bit(input logic b);
    mosi = b;
    cyc(half);
    sclk = 1'b1;
    cyc(half);
    if (rx_busy !== 1'b1) busy_bad = 1'b1;
    sclk = 1'b0;
  endtask
  task automatic frame(input string tag, input int nbits, input logic [63:0] data,
                       input bit pre_high, input bit sim_end);
    int e0;
    int nw;
    logic [7:0] exp_b;
    e0 = err_cnt;
    nw = nbits / 8;
    got_q.delete();
    t_q.delete();
    busy_bad = 1'b0;
    if (pre_high) begin
      repeat (2) begin
        sclk = 1'b1;
        cyc(half);
        sclk = 1'b0;
        cyc(half);
      end
      sclk = 1'b1;
      cyc(half);
    end
    cs_n = 1'b0;
    cyc(half);
    if (pre_high) begin
      sclk = 1'b0;
      cyc(half);
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      if (sim_end && i == 0) begin
        mosi = data[i];
        cyc(half);
        sclk = 1'b1;
        cs_n = 1'b1;
        cyc(half);
        sclk = 1'b0;
      end else begin
        send_bit(data[i]);
      end
    end
    cyc(half);
    cs_n = 1'b1;
    cyc(3 * half + 8);
    check({tag, ".nvalid"}, got_q.size(), nw);
    for (int k = 0; k < nw && k < got_q.size(); k++) begin
      exp_b = 8'(data >> (nbits - 8 * (k + 1)));
      check({tag, ".word"}, got_q[k], exp_b);
      last_data = exp_b;
    end
    if (nw >= 2 && t_q.size() >= 2) check({tag, ".spacing"}, t_q[1] - t_q[0], 16 * half);
    check({tag, ".err"}, err_cnt - e0, (nbits % 8) != 0);
    check({tag, ".hold"}, rx_data, last_data);
    check({tag, ".busy_in"}, busy_bad, 1'b0);
    check({tag, ".busy_out"}, rx_busy, 1'b0);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, ".data"}, rx_data, 8'h00);
    check({tag, ".valid"}, rx_valid, 1'b0);
    check({tag, ".busy"}, rx_busy, 1'b0);
    check({tag, ".err"}, rx_err, 1'b0);
  endtask
  initial begin
    int nb;
    int e0;
    cyc(3);
    check_reset_outputs("por");
    rst = 1'b0;
    cyc(10);
    frame("b12", 8, 64'h12, 0, 0);
    frame("b55a3", 16, 64'h55A3, 0, 0);
    frame("ff5", 5, 64'h1F, 0, 0);
    frame("b3c", 8, 64'h3C, 0, 0);
    got_q.delete();
    e0 = err_cnt;
    busy_bad = 1'b0;
    cs_n = 1'b0;
    cyc(half);
    for (int i = 0; i < 4; i++) send_bit(1'(i));
    rst = 1'b1;
    cyc(2);
    check_reset_outputs("midrst");
    rst = 1'b0;
    last_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      cyc(half);
      sclk = 1'b1;
      cyc(half);
      if (rx_busy !== 1'b0) busy_bad = 1'b1;
      sclk = 1'b0;
    end
    cyc(half);
    cs_n = 1'b1;
    cyc(3 * half + 8);
    check("midrst.nvalid", got_q.size(), 0);
    check("midrst.err", err_cnt - e0, 0);
    check("midrst.busy", busy_bad, 1'b0);
    check("midrst.hold", rx_data, 8'h00);
    frame("b81", 8, 64'h81, 0, 0);
    frame("bc6", 8, 64'hC6, 1, 0);
    frame("b7e", 8, 64'h7E, 0, 1);
    repeat (10) begin
      half = $urandom_range(5, 12);
      nb = $urandom_range(1, 24);
      frame("rnd", nb, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            (nb % 8 == 0) && ($urandom_range(0, 1) == 1));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
